xswitch_bank: RTL and testbench
===============================

// Module: xswitch_bank
// PURPOSE
//  Memory-mapped bank of N_SW debounced switch inputs for the picoVersat peripheral bus.
//  Each raw input is 2-FF synchronised, then debounced with a per-channel stability counter.
//  Rising/falling transitions latch sticky pending bits, which drive a maskable interrupt.
//  Successor to the single-value switch read port: parametrised width, edge capture, irq.
// PARAMETERS
//  N_SW          8      number of switch channels (1..DATA_W)
//  DEBOUNCE_W    16     width of each per-channel debounce counter
//  DEBOUNCE_CYC  50000  consecutive disagreeing cycles before the stable value updates (1..2^DEBOUNCE_W-1)
//  ADDR_W        3      register address width
// PORTS
//  clk       in   1       system clock
//  rst       in   1       asynchronous reset, active-low
//  sel       in   1       bus select for this block
//  we        in   1       write enable, qualified by sel
//  addr      in   ADDR_W  register address
//  data_in   in   DATA_W  write data
//  data_out  out  DATA_W  read data; 0 when sel=0
//  sw_in     in   N_SW    raw asynchronous switch inputs
//  irq       out  1       interrupt: |(PEND & IRQ_MASK)
// BEHAVIOUR
//  Reset (rst=0, async): sync FFs, STABLE, counters, PEND, RISE_EN, FALL_EN, IRQ_MASK all 0;
//   data_out=0, irq=0.
//  Register map (bits above N_SW read 0; writes to them are ignored):
//   0 STATE     RO   debounced stable value; writes ignored
//   1 PEND      W1C  sticky edge-pending bits; writing 1 clears, writing 0 has no effect
//   2 RISE_EN   RW   per-channel enable for 0->1 capture
//   3 FALL_EN   RW   per-channel enable for 1->0 capture
//   4 IRQ_MASK  RW   per-channel interrupt enable
//   5..7            read 0; writes ignored
//  Read: combinational. data_out = sel ? reg[addr] : 0. No wait states. we does not gate reads.
//  Write: takes effect on the clk edge where sel=1 and we=1.
//  Synchroniser: sync[i] = sw_in[i] delayed by 2 clk edges.
//  Debounce, per channel i:
//   - sync[i]==STABLE[i]: cnt[i] <- 0.
//   - sync[i]!=STABLE[i] and cnt[i]<DEBOUNCE_CYC-1: cnt[i] <- cnt[i]+1.
//   - sync[i]!=STABLE[i] and cnt[i]==DEBOUNCE_CYC-1: STABLE[i] <- sync[i], cnt[i] <- 0.
//   - Result: STABLE updates after exactly DEBOUNCE_CYC consecutive disagreeing cycles,
//     i.e. 2+DEBOUNCE_CYC edges after a clean sw_in change.
//   - Any agreeing cycle restarts the count, so glitches shorter than DEBOUNCE_CYC are rejected.
//   - The counter never wraps.
//  Edge capture:
//   - On the edge where STABLE[i] updates 0->1 with RISE_EN[i]=1, or 1->0 with FALL_EN[i]=1,
//     PEND[i] <- 1.
//   - Set and W1C in the same cycle: set wins, PEND[i] stays 1.
//   - Changing an enable does not affect bits already pending.
//  irq: combinational from registered PEND and IRQ_MASK. Masking a pending bit drops irq
//   without clearing PEND.
//  Reset mid-debounce discards the partial count. After reset, a switch held high must be
//   re-debounced from STABLE=0. That update captures a rising edge only if RISE_EN is
//   already set by then.
// TESTING (bench uses N_SW=4, DEBOUNCE_CYC=4)
//  1. Assert rst=0 with sw_in=4'hF -> STATE=0, PEND=0, irq=0, data_out=0 while sel=0.
//  2. sw_in[0] high for 3 cycles then low -> STATE stays 0, PEND stays 0 (glitch rejected).
//  3. RISE_EN=1, IRQ_MASK=1, sw_in[0] 0->1 held -> STATE=4'h1 exactly 6 edges later,
//     PEND=4'h1, irq=1.
//  4. Write PEND=4'h1 -> PEND=0, irq=0. Write PEND=4'h1 on the same edge as a new capture
//     on ch0 -> PEND=4'h1 (set wins).
//  5. FALL_EN=4'h2, RISE_EN=0, toggle sw_in[1] 0->1->0 (each held 10 cycles)
//     -> PEND=4'h2 only after the fall.
//  6. Pulse rst low while ch2 cnt=2 -> cnt and STATE cleared; write STATE=4'hF
//     -> STATE unchanged; read addr 6 -> 0.

Source files
------------

// File: rtl/xswitch_bank.sv
// xswitch_bank -- memory-mapped bank of debounced switch inputs.
//
// Each raw switch input is brought into the clk domain with a two-flop
// synchroniser. A per-channel stability counter then filters it. When the
// filtered (STABLE) value changes, a sticky pending bit can be latched. Rising
// and falling edges are enabled separately per channel. The pending bits,
// qualified by a per-channel mask, drive a level interrupt.
//
// Register map (bits above N_SW read as 0; writes to them are ignored):
//   0 STATE    RO   debounced stable value
//   1 PEND     W1C  sticky edge-pending bits
//   2 RISE_EN  RW   0->1 capture enable
//   3 FALL_EN  RW   1->0 capture enable
//   4 IRQ_MASK RW   interrupt enable
//   5..7           read 0, writes ignored
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   sel       bus select for this block
//   we        write enable, qualified by sel
//   addr      register address
//   data_in   write data
//   data_out  combinational read data, 0 when sel=0
//   sw_in     raw asynchronous switch inputs
//   irq       |(PEND & IRQ_MASK)
module xswitch_bank #(
  parameter int N_SW         = 8,
  parameter int DEBOUNCE_W   = 16,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [N_SW-1:0]   sw_in,
  output logic              irq
);

  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYC - 1);

  localparam logic [ADDR_W-1:0] A_STATE = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PEND  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RISE  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_FALL  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(4);

  logic [N_SW-1:0] sync_meta;
  logic [N_SW-1:0] sync;
  logic [N_SW-1:0] stable;
  logic [N_SW-1:0] rise_evt;
  logic [N_SW-1:0] fall_evt;
  logic [N_SW-1:0] pend;
  logic [N_SW-1:0] rise_en;
  logic [N_SW-1:0] fall_en;
  logic [N_SW-1:0] irq_mask;
  logic [N_SW-1:0] pend_set;
  logic [N_SW-1:0] pend_clr;
  logic [N_SW-1:0] wdata;
  logic            wr;
  logic [DATA_W-1:0] rd_word;

  // Only the low N_SW bits of data_in are meaningful; fold the rest away.
  logic data_in_unused;
  assign data_in_unused = ^data_in;

  assign wr    = sel & we;
  assign wdata = data_in[N_SW-1:0];

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= sw_in;
      sync      <= sync_meta;
    end
  end

  // Per-channel debounce. The counter counts consecutive cycles where the
  // synchronised input disagrees with STABLE. Any agreeing cycle restarts it.
  // On the DEBOUNCE_CYC-th disagreeing cycle STABLE takes the new value and
  // the counter returns to 0, so it never wraps.
  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
      logic [DEBOUNCE_W-1:0] cnt;
      logic                  stab;
      logic                  differ;
      logic                  upd;

      assign differ = sync[gi] ^ stab;
      assign upd    = differ && (cnt == CNT_LAST);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt  <= '0;
          stab <= 1'b0;
        end else if (!differ) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stab <= sync[gi];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign stable[gi]   = stab;
      // Updates always move STABLE towards sync, so sync gives the edge direction.
      assign rise_evt[gi] = upd & sync[gi];
      assign fall_evt[gi] = upd & ~sync[gi];
    end
  endgenerate

  assign pend_set = (rise_evt & rise_en) | (fall_evt & fall_en);
  assign pend_clr = (wr && addr == A_PEND) ? wdata : '0;

  // Control registers. The OR with pend_set comes after the W1C clear, so a
  // capture on the same edge as a clear keeps the bit pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      if (wr && addr == A_RISE) rise_en  <= wdata;
      if (wr && addr == A_FALL) fall_en  <= wdata;
      if (wr && addr == A_MASK) irq_mask <= wdata;
    end
  end

  // Combinational read. we does not gate reads.
  always_comb begin
    rd_word = '0;
    case (addr)
      A_STATE: rd_word[N_SW-1:0] = stable;
      A_PEND:  rd_word[N_SW-1:0] = pend;
      A_RISE:  rd_word[N_SW-1:0] = rise_en;
      A_FALL:  rd_word[N_SW-1:0] = fall_en;
      A_MASK:  rd_word[N_SW-1:0] = irq_mask;
      default: rd_word = '0;
    endcase
    data_out = sel ? rd_word : '0;
  end

  assign irq = |(pend & irq_mask);

endmodule

// File: tb/tb_xswitch_bank.sv
// Testbench for xswitch_bank (N_SW=4, DEBOUNCE_CYC=4).
// Reference model: STABLE[i] flips when the last DEBOUNCE_CYC synchronised
// samples all differ from it. The synchronised sample is sw_in from two
// edges earlier. Registers follow the register-map rules directly.
module tb_xswitch_bank;
  localparam int N   = 4;
  localparam int CYC = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  sw_in;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [3:0] m_d1, m_d2, m_stable, m_pend, m_rise, m_fall, m_mask;
  logic [3:0] hist[$];

  xswitch_bank #(
    .N_SW(N), .DEBOUNCE_W(16), .DEBOUNCE_CYC(CYC), .ADDR_W(3), .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .sw_in(sw_in), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_clear();
    m_d1 = 0; m_d2 = 0; m_stable = 0; m_pend = 0;
    m_rise = 0; m_fall = 0; m_mask = 0;
    hist.delete();
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_stable};
      3'd1: return {28'd0, m_pend};
      3'd2: return {28'd0, m_rise};
      3'd3: return {28'd0, m_fall};
      3'd4: return {28'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the current inputs, then let
  // the DUT take the same edge. Returns 1 ns after the edge.
  task automatic step();
    logic [3:0] newst, set, clr;
    bit all_diff;
    if (rst) begin
      hist.push_back(m_d2);
      if (hist.size() > CYC) void'(hist.pop_front());
      newst = m_stable;
      if (hist.size() == CYC) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1;
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 0;
          if (all_diff) newst[i] = ~m_stable[i];
        end
      end
      set = (newst & ~m_stable & m_rise) | (~newst & m_stable & m_fall);
      clr = (sel && we && addr == 3'd1) ? data_in[3:0] : 4'd0;
      m_pend = (m_pend & ~clr) | set;
      if (sel && we && addr == 3'd2) m_rise = data_in[3:0];
      if (sel && we && addr == 3'd3) m_fall = data_in[3:0];
      if (sel && we && addr == 3'd4) m_mask = data_in[3:0];
      m_stable = newst;
      m_d2 = m_d1;
      m_d1 = sw_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; data_in = d;
    step();
    sel = 0; we = 0; data_in = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    sel = 1; we = 0; addr = a;
    #1;
    v = data_out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    sw_in = 4'hF; sel = 0; we = 0; addr = 0; data_in = 0;
    rst = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL reset_dout_unsel: got %h want %h", data_out, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", a, v); end
    end
    sel = 0;
    sw_in = 4'h0;
    #2 rst = 1;
    step();
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    sw_in[0] = 1;
    steps(3);
    sw_in[0] = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      rd(0, v);
      checks++; if (v !== model_rd(0) || v !== 32'd0) begin errors++; $display("FAIL glitch_state cyc%0d: got %h want %h", i, v, model_rd(0)); end
    end
    rd(1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL glitch_pend: got %h want 0", v); end
  endtask

  task automatic test_rise();
    logic [31:0] v;
    wr(2, 32'h1);
    wr(4, 32'h1);
    sw_in[0] = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      rd(0, v);
      checks++; if (v !== model_rd(0)) begin errors++; $display("FAIL rise_state edge%0d: got %h want %h", i, v, model_rd(0)); end
    end
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL rise_state_6: got %h want 1", v); end
    rd(1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL rise_pend: got %h want 1", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq); end
  endtask

  task automatic test_w1c_set_wins();
    logic [31:0] v;
    wr(1, 32'h1);
    rd(1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL w1c_pend: got %h want 0", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
    sw_in[0] = 0;
    steps(6);
    rd(0, v);
    checks++; if (v !== model_rd(0)) begin errors++; $display("FAIL w1c_fall_state: got %h want %h", v, model_rd(0)); end
    sw_in[0] = 1;
    steps(5);
    wr(1, 32'h1);   // clear lands on the capture edge
    rd(1, v);
    checks++; if (v !== 32'h1 || v !== model_rd(1)) begin errors++; $display("FAIL set_wins_pend: got %h want %h", v, 32'h1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", irq); end
  endtask

  task automatic test_fall();
    logic [31:0] v;
    wr(1, 32'hF);
    wr(3, 32'h2);
    wr(2, 32'h0);
    sw_in[1] = 1;
    steps(10);
    rd(1, v);
    checks++; if (v !== model_rd(1) || v !== 32'h0) begin errors++; $display("FAIL fall_pend_after_rise: got %h want 0", v); end
    sw_in[1] = 0;
    steps(10);
    rd(1, v);
    checks++; if (v !== model_rd(1) || v !== 32'h2) begin errors++; $display("FAIL fall_pend_after_fall: got %h want 2", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_irq_masked: got %b want 0", irq); end
    wr(4, 32'h2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq_unmasked: got %b want 1", irq); end
    wr(4, 32'h0);
    rd(1, v);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_drop_irq: got %b want 0", irq); end
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL mask_keeps_pend: got %h want 2", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    sw_in[2] = 1;
    steps(4);   // ch2 counter is now 2 of 4
    rst = 0;
    model_clear();
    #2 rst = 1;
    rd(0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_state: got %h want 0", v); end
    for (int i = 1; i <= 6; i++) begin
      step();
      rd(0, v);
      checks++; if (v !== model_rd(0)) begin errors++; $display("FAIL redebounce edge%0d: got %h want %h", i, v, model_rd(0)); end
    end
    checks++; if (v[2] !== 1'b1) begin errors++; $display("FAIL redebounce_ch2: got %b want 1", v[2]); end
    rd(1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL redebounce_no_pend: got %h want 0", v); end
    wr(0, 32'hF);
    rd(0, v);
    checks++; if (v !== model_rd(0)) begin errors++; $display("FAIL state_ro: got %h want %h", v, model_rd(0)); end
    wr(6, 32'hF);
    wr(5, 32'hF);
    rd(6, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL addr6_read: got %h want 0", v); end
    for (int a = 1; a < 5; a++) begin
      rd(3'(a), v);
      checks++; if (v !== model_rd(3'(a))) begin errors++; $display("FAIL unmapped_wr reg%0d: got %h want %h", a, v, model_rd(3'(a))); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [2:0]  a;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) sw_in[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 9) < 2) begin
        wr(3'($urandom_range(0, 7)), $urandom);
      end else begin
        sel = 1'($urandom_range(0, 1)); we = 0; addr = 3'($urandom_range(0, 7));
        step();
      end
      if ($urandom_range(0, 7) == 0) begin
        sel = 0; addr = 3'($urandom_range(0, 7)); #1;
        checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL rand_unsel cyc%0d: got %h want 0", i, data_out); end
      end else begin
        a = 3'($urandom_range(0, 7));
        rd(a, v);
        checks++; if (v !== model_rd(a)) begin errors++; $display("FAIL rand_read cyc%0d addr%0d: got %h want %h", i, a, v, model_rd(a)); end
      end
      checks++; if (irq !== |(m_pend & m_mask)) begin errors++; $display("FAIL rand_irq cyc%0d: got %b want %b", i, irq, |(m_pend & m_mask)); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_w1c_set_wins();
    test_fall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
